mem_responder: RTL

- Memory-side responder for the multicycle processor's data/instruction memory port.
- The controller and datapath present a request (address, write data, write enable). This block services it from a word-addressed RAM after a configurable number of wait states, then returns read data with a one-cycle ready pulse.
- Sits between the datapath's Adr/WriteData/MemWrite nets and the memory array. It replaces the ideal zero-latency memory, so stall handling in the FSM can be exercised.

---
 rtl/mem_responder_pkg.sv | 37 +++
 rtl/mem_word_array.sv | 37 +++
 rtl/mem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//
// Purpose:
//   Shared definitions for the memory responder: FSM state encoding, default
//   geometry/latency constants, the wait-counter width and a small alignment
//   helper used by the top level.
//
// Contents:
//   state_e               FSM state encoding (S_IDLE, S_WAIT, S_RESP)
//   DEFAULT_DEPTH_WORDS   default number of 32-bit words in the array
//   DEFAULT_ADDR_BITS     default word-index width (log2 of depth)
//   DEFAULT_WAIT_CYCLES   default wait states between accept and response
//   CNT_W                 width of the wait-state counter
//   is_word_aligned()     true when a byte address is word aligned
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    // 2'b11 is not a legal state; the FSM recovers from it to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_ADDR_BITS   = 6;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Wide enough for the full legal wait range 0..15.
    localparam int CNT_W = 4;

    function automatic logic is_word_aligned(input logic [1:0] byte_lsbs);
        return (byte_lsbs == 2'b00);
    endfunction

endpackage : mem_responder_pkg

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
//
// Purpose:
//   DEPTH_WORDS x 32-bit storage with a synchronous write port and a
//   combinational read port sharing one word index. Contents are not reset;
//   a location is undefined until it has been written.
//
// Ports:
//   clk      in   clock; writes happen on the rising edge
//   we_i     in   write enable
//   idx_i    in   word index for both read and write
//   wdata_i  in   write data
//   rdata_o  out  combinational read data at idx_i (pre-write contents)
// -----------------------------------------------------------------------------
module mem_word_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_BITS   = 6
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] idx_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule : mem_word_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   Memory-side responder for the multicycle processor's memory port. A
//   request (byte address, write data, write enable) is accepted in IDLE,
//   held for WAIT_CYCLES wait states, then serviced from a word-addressed
//   array. Completion is marked by a one-cycle MemReady pulse; misaligned
//   addresses complete with MemError and leave the array untouched.
//
// Handshake:
//   MemReq is a request strobe sampled only while the FSM is in IDLE
//   (Busy=0). The edge that sees MemReq=1 in IDLE accepts the request and
//   latches Adr/WriteData/MemWrite; those inputs may change freely afterwards.
//   Exactly WAIT_CYCLES edges later the FSM enters RESP, where MemReady is
//   high for exactly one cycle (with MemError if the latched address was not
//   word aligned). MemReq seen in WAIT or RESP is dropped, not queued, so the
//   requester must keep MemReq up (or re-raise it) until it sees the request
//   accepted via Busy.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   reset        in   asynchronous active-low reset
//   MemReq       in   request strobe
//   MemWrite     in   1 = write, 0 = read
//   Adr          in   byte address (upper bits ignored: addresses alias)
//   WriteData    in   store data
//   ReadData     out  registered read data, held until the next response
//   MemReady     out  one-cycle completion pulse
//   MemError     out  misaligned-address flag, valid with MemReady
//   Busy         out  high whenever the FSM is not in IDLE
//   dbg_state_o  out  current FSM state encoding
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        Busy,
    output logic [1:0]  dbg_state_o
);

    localparam int LAT_W = ADDR_BITS + 2;   // byte-address bits that matter

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LAT_W-1:0]   adr_q;
    logic [31:0]        wdata_q;
    logic               we_q;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               error_q;
    logic               busy_q;

    // ------------------------------------------------------------------
    // Effective request fields
    // With WAIT_CYCLES=0 the edge that accepts a request is also the edge
    // that enters RESP, so the latched copies are not yet valid there. In
    // IDLE the live inputs are used; in every other state the latched ones.
    // ------------------------------------------------------------------
    logic               in_idle;
    logic               accept;
    logic               enter_resp;
    logic [LAT_W-1:0]   eff_adr;
    logic [31:0]        eff_wdata;
    logic               eff_we;
    logic               eff_aligned;
    logic [ADDR_BITS-1:0] eff_idx;
    logic               arr_we;
    logic [31:0]        arr_rdata;
    logic [31:0]        resp_data;

    assign in_idle = (state_q == S_IDLE);
    assign accept  = in_idle && MemReq;

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));

    assign eff_adr     = in_idle ? Adr[LAT_W-1:0] : adr_q;
    assign eff_wdata   = in_idle ? WriteData      : wdata_q;
    assign eff_we      = in_idle ? MemWrite       : we_q;
    assign eff_aligned = is_word_aligned(eff_adr[1:0]);
    assign eff_idx     = eff_adr[LAT_W-1:2];

    // The array is written on the same edge that enters RESP.
    assign arr_we = enter_resp && eff_we && eff_aligned;

    // Misaligned accesses return zero; aligned writes echo the stored value.
    always_comb begin
        resp_data = 32'h0;
        if (eff_aligned) begin
            resp_data = eff_we ? eff_wdata : arr_rdata;
        end
    end

    // Address bits above the word index alias and are intentionally dropped.
    logic unused_adr_hi;
    assign unused_adr_hi = ^Adr[31:LAT_W];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .idx_i   (eff_idx),
        .wdata_i (eff_wdata),
        .rdata_o (arr_rdata)
    );

    // ------------------------------------------------------------------
    // FSM, request latches and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // MemReady/MemError are single-cycle pulses unless re-armed below.
            ready_q <= 1'b0;
            error_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (MemReq) begin
                        adr_q   <= Adr[LAT_W-1:0];
                        wdata_q <= WriteData;
                        we_q    <= MemWrite;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                ready_q <= 1'b1;
                error_q <= ~eff_aligned;
                rdata_q <= resp_data;
            end
        end
    end

    assign ReadData    = rdata_q;
    assign MemReady    = ready_q;
    assign MemError    = error_q;
    assign Busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule : mem_responder
